// File: rtl/mtsp_mem_cmd_pkg.sv
// Shared types for the memory-command issuer: FSM states and the command record.
// Pure declarations: no latency, no backpressure.
package mtsp_mem_cmd_pkg;

    localparam int CMD_SIZE_W  = 8;
    localparam int DEF_GADDR_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GAP,
        WAIT,
        DONE
    } state_t;

    // gaddr is sized to the default line-address width of the GMB.
    typedef struct packed {
        logic                   we;
        logic                   cache_en;
        logic                   cache_only;
        logic [DEF_GADDR_W-1:0] gaddr;
        logic [CMD_SIZE_W-1:0]  size;
    } mem_cmd_t;

endpackage

// File: rtl/mtsp_mem_cmd_issuer.sv
// Splits one load/store request into MAX_BURST-line command pulses; at least 3 cycles between pulses.
// Accepts only in IDLE (REQ_READY); after each pulse it waits for MEM_BUSY to drop.
module mtsp_mem_cmd_issuer
    import mtsp_mem_cmd_pkg::*;
#(
    parameter int GADDR_W   = 10,
    parameter int LEN_W     = 16,
    parameter int MAX_BURST = 255
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               REQ_VALID,
    output logic               REQ_READY,
    input  logic               REQ_WE,
    input  logic               REQ_CACHE_EN,
    input  logic               REQ_CACHE_ONLY,
    input  logic [GADDR_W-1:0] REQ_GADDR,
    input  logic [LEN_W-1:0]   REQ_LEN,
    output logic               CMD_REQ,
    output logic [7:0]         CMD_SIZE,
    output logic [GADDR_W-1:0] CMD_GADDR,
    output logic               CMD_WE,
    output logic               CMD_CACHE_EN,
    output logic               CMD_CACHE_ONLY,
    input  logic               MEM_BUSY,
    input  logic               ABORT,
    output logic               BUSY,
    output logic               DONE
);

    state_t             state;
    state_t             state_nxt;
    logic [LEN_W-1:0]   r_left;
    logic [LEN_W-1:0]   chunk_len;
    logic [GADDR_W-1:0] r_addr;
    logic               abort_pend;
    logic               accept;
    mem_cmd_t           r_cmd;
    mem_cmd_t           cmd;

    assign accept = REQ_VALID && (state == IDLE);

    // Compared at full length width so long requests never alias into a small chunk.
    assign chunk_len = (r_left > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : r_left;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (REQ_VALID) begin
                    state_nxt = (REQ_LEN == '0) ? mtsp_mem_cmd_pkg::DONE : ISSUE;
                end
            end
            ISSUE: state_nxt = GAP;
            // MEM_BUSY is registered in the mover, so it is not yet valid here.
            GAP:   state_nxt = WAIT;
            WAIT: begin
                if (!MEM_BUSY) begin
                    state_nxt = ((r_left == '0) || abort_pend) ? mtsp_mem_cmd_pkg::DONE : ISSUE;
                end
            end
            mtsp_mem_cmd_pkg::DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_left     <= '0;
            r_addr     <= '0;
            r_cmd      <= '0;
            abort_pend <= 1'b0;
        end else begin
            if (accept) begin
                r_left           <= REQ_LEN;
                r_addr           <= REQ_GADDR;
                r_cmd.we         <= REQ_WE;
                r_cmd.cache_en   <= REQ_CACHE_EN;
                r_cmd.cache_only <= REQ_CACHE_ONLY;
            end
            if (state == ISSUE) begin
                r_left      <= r_left - chunk_len;
                r_addr      <= r_addr + GADDR_W'(chunk_len);
                r_cmd.size  <= CMD_SIZE_W'(chunk_len);
                r_cmd.gaddr <= DEF_GADDR_W'(r_addr);
            end
            if (state == mtsp_mem_cmd_pkg::DONE) begin
                abort_pend <= 1'b0;
            end else if (ABORT && (state != IDLE)) begin
                abort_pend <= 1'b1;
            end
        end
    end

    // Command fields show the live chunk during ISSUE and hold the last one otherwise.
    always_comb begin
        cmd = r_cmd;
        if (state == ISSUE) begin
            cmd.size  = CMD_SIZE_W'(chunk_len);
            cmd.gaddr = DEF_GADDR_W'(r_addr);
        end
        REQ_READY      = (state == IDLE);
        CMD_REQ        = (state == ISSUE);
        BUSY           = (state != IDLE);
        DONE           = (state == mtsp_mem_cmd_pkg::DONE);
        CMD_SIZE       = cmd.size;
        CMD_GADDR      = GADDR_W'(cmd.gaddr);
        CMD_WE         = cmd.we;
        CMD_CACHE_EN   = cmd.cache_en;
        CMD_CACHE_ONLY = cmd.cache_only;
    end

endmodule

// File: tb/tb_mtsp_mem_cmd_issuer.sv
// Bench for mtsp_mem_cmd_issuer: behavioural mover plus a queue of expected commands.
module tb_mtsp_mem_cmd_issuer;

    localparam int GW = 10;
    localparam int LW = 16;
    localparam int MB = 255;

    logic          CLK = 1'b0;
    logic          RST;
    logic          REQ_VALID;
    logic          REQ_READY;
    logic          REQ_WE;
    logic          REQ_CACHE_EN;
    logic          REQ_CACHE_ONLY;
    logic [GW-1:0] REQ_GADDR;
    logic [LW-1:0] REQ_LEN;
    logic          CMD_REQ;
    logic [7:0]    CMD_SIZE;
    logic [GW-1:0] CMD_GADDR;
    logic          CMD_WE;
    logic          CMD_CACHE_EN;
    logic          CMD_CACHE_ONLY;
    logic          MEM_BUSY;
    logic          ABORT;
    logic          BUSY;
    logic          DONE;

    typedef struct packed {
        logic          we;
        logic          ce;
        logic          co;
        logic [GW-1:0] ga;
        logic [7:0]    sz;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   done_cnt    = 0;
    int   done_cyc    = 0;
    int   fall_cyc    = 0;
    int   cmd_cnt     = 0;
    logic prev_busy   = 1'b0;
    int   mv_cnt;

    mtsp_mem_cmd_issuer #(.GADDR_W(GW), .LEN_W(LW), .MAX_BURST(MB)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .REQ_VALID     (REQ_VALID),
        .REQ_READY     (REQ_READY),
        .REQ_WE        (REQ_WE),
        .REQ_CACHE_EN  (REQ_CACHE_EN),
        .REQ_CACHE_ONLY(REQ_CACHE_ONLY),
        .REQ_GADDR     (REQ_GADDR),
        .REQ_LEN       (REQ_LEN),
        .CMD_REQ       (CMD_REQ),
        .CMD_SIZE      (CMD_SIZE),
        .CMD_GADDR     (CMD_GADDR),
        .CMD_WE        (CMD_WE),
        .CMD_CACHE_EN  (CMD_CACHE_EN),
        .CMD_CACHE_ONLY(CMD_CACHE_ONLY),
        .MEM_BUSY      (MEM_BUSY),
        .ABORT         (ABORT),
        .BUSY          (BUSY),
        .DONE          (DONE)
    );

    always #5 CLK = ~CLK;

    // Mover: busy from the cycle after a command strobe, for CMD_SIZE cycles.
    always @(posedge CLK or posedge RST) begin
        if (RST) mv_cnt <= 0;
        else if (CMD_REQ) mv_cnt <= int'(CMD_SIZE);
        else if (mv_cnt != 0) mv_cnt <= mv_cnt - 1;
    end
    assign MEM_BUSY = (mv_cnt != 0);

    // Monitor: every command strobe is scored against the head of the expected queue.
    always @(negedge CLK) begin
        exp_t e;
        exp_t got;
        cyc = cyc + 1;
        if (prev_busy && (MEM_BUSY === 1'b0)) fall_cyc = cyc;
        prev_busy = MEM_BUSY;
        if (DONE === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (CMD_REQ === 1'b1) begin
            cmd_cnt = cmd_cnt + 1;
            vectors = vectors + 1;
            if (MEM_BUSY !== 1'b0) begin
                miscompares = miscompares + 1;
                $display("FAIL cmd_while_busy MEM_BUSY=%b required=0", MEM_BUSY);
            end
            vectors = vectors + 1;
            got = {CMD_WE, CMD_CACHE_EN, CMD_CACHE_ONLY, CMD_GADDR, CMD_SIZE};
            if (exp_q.size() == 0) begin
                miscompares = miscompares + 1;
                $display("FAIL unexpected_cmd size=%0d gaddr=%h required=no command", CMD_SIZE, CMD_GADDR);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    miscompares = miscompares + 1;
                    $display("FAIL cmd got we/ce/co=%b%b%b size=%0d gaddr=%h required we/ce/co=%b%b%b size=%0d gaddr=%h",
                             got.we, got.ce, got.co, got.sz, got.ga, e.we, e.ce, e.co, e.sz, e.ga);
                end
            end
        end
    end

    function automatic void push(input logic we, input logic ce, input logic co,
                                 input logic [GW-1:0] ga, input logic [7:0] sz);
        exp_t e;
        e.we = we; e.ce = ce; e.co = co; e.ga = ga; e.sz = sz;
        exp_q.push_back(e);
    endfunction

    task automatic start_req(input logic we, input logic ce, input logic co,
                             input logic [GW-1:0] ga, input logic [LW-1:0] len, output int acc_cyc);
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_WE = we; REQ_CACHE_EN = ce; REQ_CACHE_ONLY = co;
        REQ_GADDR = ga; REQ_LEN = len;
        @(posedge CLK);
        acc_cyc = cyc;
        #1 REQ_VALID = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int d0, input int budget);
        int i = 0;
        while (done_cnt == d0 && i < budget) begin
            @(posedge CLK);
            i++;
        end
        vectors = vectors + 1;
        if (done_cnt == d0) begin
            miscompares = miscompares + 1;
            $display("FAIL %s_timeout done_pulses=0 required=1 within %0d cycles", nm, budget);
        end
        repeat (4) @(posedge CLK);
        vectors = vectors + 1;
        if (done_cnt != d0 + 1) begin
            miscompares = miscompares + 1;
            $display("FAIL %s_done_count got=%0d required=1", nm, done_cnt - d0);
        end
        vectors = vectors + 1;
        if (exp_q.size() != 0) begin
            miscompares = miscompares + 1;
            $display("FAIL %s_missing_cmds got=%0d outstanding required=0", nm, exp_q.size());
        end
    endtask

    task automatic test_reset();
        #1;
        vectors = vectors + 4;
        if (REQ_READY !== 1'b1) begin miscompares++; $display("FAIL rst_ready got=%b required=1", REQ_READY); end
        if ({CMD_REQ, BUSY, DONE} !== 3'b000) begin
            miscompares++; $display("FAIL rst_ctrl req/busy/done got=%b%b%b required=000", CMD_REQ, BUSY, DONE);
        end
        if ({CMD_SIZE, CMD_GADDR} !== '0) begin
            miscompares++; $display("FAIL rst_fields size=%0d gaddr=%h required=0/0", CMD_SIZE, CMD_GADDR);
        end
        if ({CMD_WE, CMD_CACHE_EN, CMD_CACHE_ONLY} !== 3'b000) begin
            miscompares++; $display("FAIL rst_flags got=%b%b%b required=000", CMD_WE, CMD_CACHE_EN, CMD_CACHE_ONLY);
        end
    endtask

    task automatic test_single();
        int d0 = done_cnt;
        int acc;
        push(1'b1, 1'b1, 1'b0, 10'h010, 8'd5);
        start_req(1'b1, 1'b1, 1'b0, 10'h010, 16'd5, acc);
        wait_done("single", d0, 200);
        vectors = vectors + 1;
        if (done_cyc - fall_cyc != 1) begin
            miscompares++; $display("FAIL single_done_latency got=%0d required=1", done_cyc - fall_cyc);
        end
    endtask

    task automatic test_multi_chunk();
        int d0 = done_cnt;
        int acc;
        push(1'b0, 1'b0, 1'b1, 10'h100, 8'd255);
        push(1'b0, 1'b0, 1'b1, 10'h1FF, 8'd255);
        push(1'b0, 1'b0, 1'b1, 10'h2FE, 8'd90);
        start_req(1'b0, 1'b0, 1'b1, 10'h100, 16'd600, acc);
        wait_done("multi", d0, 2000);
        vectors = vectors + 2;
        if ({CMD_SIZE, CMD_GADDR} !== {8'd90, 10'h2FE}) begin
            miscompares++; $display("FAIL multi_hold size=%0d gaddr=%h required=90/2fe", CMD_SIZE, CMD_GADDR);
        end
        if ({CMD_REQ, CMD_CACHE_ONLY, REQ_READY} !== 3'b011) begin
            miscompares++; $display("FAIL multi_idle req/co/ready got=%b%b%b required=011", CMD_REQ, CMD_CACHE_ONLY, REQ_READY);
        end
    endtask

    task automatic test_len_zero();
        int d0 = done_cnt;
        int c0 = cmd_cnt;
        int acc;
        start_req(1'b1, 1'b0, 1'b0, 10'h055, 16'd0, acc);
        wait_done("len0", d0, 20);
        vectors = vectors + 2;
        if (cmd_cnt != c0) begin
            miscompares++; $display("FAIL len0_cmds got=%0d required=0", cmd_cnt - c0);
        end
        if (done_cyc - acc < 1 || done_cyc - acc > 2) begin
            miscompares++; $display("FAIL len0_latency got=%0d required=1..2", done_cyc - acc);
        end
    endtask

    task automatic test_wrap();
        int d0;
        int acc;
        @(negedge CLK) ABORT = 1'b1;
        @(negedge CLK) ABORT = 1'b0;
        d0 = done_cnt;
        push(1'b1, 1'b0, 1'b0, 10'h3F0, 8'd32);
        start_req(1'b1, 1'b0, 1'b0, 10'h3F0, 16'd32, acc);
        wait_done("wrap32", d0, 200);
        d0 = done_cnt;
        push(1'b0, 1'b1, 1'b1, 10'h3FF, 8'd255);
        push(1'b0, 1'b1, 1'b1, 10'h0FE, 8'd1);
        start_req(1'b0, 1'b1, 1'b1, 10'h3FF, 16'd256, acc);
        wait_done("wrap256", d0, 1000);
    endtask

    task automatic test_abort();
        int d0 = done_cnt;
        int acc;
        int i = 0;
        push(1'b1, 1'b1, 1'b0, 10'h100, 8'd255);
        start_req(1'b1, 1'b1, 1'b0, 10'h100, 16'd600, acc);
        while (MEM_BUSY !== 1'b1 && i < 20) begin @(posedge CLK); #1; i++; end
        @(posedge CLK);
        vectors = vectors + 1;
        if (BUSY !== 1'b1) begin miscompares++; $display("FAIL abort_busy got=%b required=1", BUSY); end
        @(negedge CLK) ABORT = 1'b1;
        @(negedge CLK) ABORT = 1'b0;
        wait_done("abort", d0, 2000);
    endtask

    task automatic test_reset_mid();
        int d0 = done_cnt;
        int c0 = cmd_cnt;
        int acc;
        int i = 0;
        push(1'b0, 1'b1, 1'b0, 10'h100, 8'd255);
        push(1'b0, 1'b1, 1'b0, 10'h1FF, 8'd255);
        push(1'b0, 1'b1, 1'b0, 10'h2FE, 8'd90);
        start_req(1'b0, 1'b1, 1'b0, 10'h100, 16'd600, acc);
        while (cmd_cnt < c0 + 2 && i < 1000) begin @(posedge CLK); i++; end
        repeat (3) @(posedge CLK);
        vectors = vectors + 1;
        if (exp_q.size() != 1 || MEM_BUSY !== 1'b1) begin
            miscompares++; $display("FAIL rstmid_setup outstanding=%0d busy=%b required=1/1", exp_q.size(), MEM_BUSY);
        end
        @(negedge CLK) RST = 1'b1;
        #1;
        vectors = vectors + 3;
        if ({REQ_READY, BUSY, CMD_REQ, DONE} !== 4'b1000) begin
            miscompares++; $display("FAIL rstmid_ctrl ready/busy/req/done got=%b%b%b%b required=1000", REQ_READY, BUSY, CMD_REQ, DONE);
        end
        if ({CMD_SIZE, CMD_GADDR, CMD_WE, CMD_CACHE_EN, CMD_CACHE_ONLY} !== '0) begin
            miscompares++; $display("FAIL rstmid_fields size=%0d gaddr=%h flags=%b%b%b required=0", CMD_SIZE, CMD_GADDR, CMD_WE, CMD_CACHE_EN, CMD_CACHE_ONLY);
        end
        exp_q.delete();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        if (done_cnt != d0) begin
            miscompares++; $display("FAIL rstmid_no_done got=%0d required=0", done_cnt - d0);
        end
        d0 = done_cnt;
        push(1'b1, 1'b0, 1'b1, 10'h005, 8'd3);
        start_req(1'b1, 1'b0, 1'b1, 10'h005, 16'd3, acc);
        wait_done("post_rst", d0, 200);
    endtask

    initial begin
        RST = 1'b1; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_CACHE_EN = 1'b0; REQ_CACHE_ONLY = 1'b0;
        REQ_GADDR = '0; REQ_LEN = '0; ABORT = 1'b0;
        repeat (3) @(negedge CLK);
        test_reset();
        @(negedge CLK) RST = 1'b0;
        test_reset();
        repeat (2) @(posedge CLK);
        test_single();
        test_multi_chunk();
        test_len_zero();
        test_wrap();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
